bank_biu_linefill: RTL
======================

Name: bank_biu_linefill

Overview:
- Bus-interface side of the bank's linefill path; producer of the linefill-return notification (rvalid/rid) consumed by the bank issue queue.
- Accepts linefill requests from the ISU, tagged by 6-bit set/way id. Issues one 2-beat read burst per request on an AXI-style AR/R interface.
- Writes each returned beat into the data RAM. After the last beat, pulses the return notification to the ISU with the originating id.
- Tracks up to OUTSTANDING concurrent linefills. R beats of different ids may interleave.

Parameters:
- ADDR_WIDTH, 32, line-aligned physical address width.
- DATA_WIDTH, 128, R beat width; one beat = one cacheline offset.
- OUTSTANDING, 4, tracking-table entries, i.e. maximum concurrent linefills.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- isu_biu_req_valid_i  in  1  linefill request valid
- isu_biu_req_ready_o  out  1  request accepted when valid&ready
- isu_biu_req_id_i  in  6  set/way id; also used as the AXI id
- isu_biu_req_addr_i  in  ADDR_WIDTH  line address; low 5 bits are ignored and driven as 0
- biu_arvalid_o  out  1  read address valid
- biu_arready_i  in  1  read address ready
- biu_arid_o  out  6  read id
- biu_araddr_o  out  ADDR_WIDTH  read address
- biu_arlen_o  out  8  constant 1 (2 beats)
- biu_arsize_o  out  3  constant 3'd4 (16 B)
- biu_rvalid_i  in  1  read data valid
- biu_rready_o  out  1  read data ready
- biu_rid_i  in  6  read data id
- biu_rdata_i  in  DATA_WIDTH  read data
- biu_rresp_i  in  2  read response; nonzero = error
- biu_rlast_i  in  1  last beat
- biu_dram_wen_o  out  1  data RAM write enable
- biu_dram_waddr_o  out  7  {id, offset}
- biu_dram_wdata_o  out  DATA_WIDTH  data RAM write data
- biu_isu_rvalid_o  out  1  linefill complete, one-cycle pulse
- biu_isu_rid_o  out  6  id of the completed linefill
- biu_isu_rerr_o  out  1  completed linefill saw a nonzero rresp
- biu_proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset: synchronous, active-high, on clk_i rising edge.
  - Clears all table entries, the AR slot and the sticky error.
  - All outputs are 0 during reset and in the first cycle after it, except biu_arlen_o and biu_arsize_o, which are constants.
  - biu_rready_o is 0 during reset and 1 at all times otherwise. There is no R backpressure; the data RAM write port is dedicated.
- Table entry fields: valid, id[5:0], beat (1b), err (1b).
- Request acceptance: ready = free entry exists & no valid entry holds req_id & (AR slot empty | biu_arready_i).
  - Ready is computed from registered state only. An entry freed this cycle is not reusable until the next cycle. A duplicate of an entry completing this cycle is still rejected.
- On acceptance:
  - Allocate the lowest-index free entry: beat=0, err=0.
  - Load the AR slot; biu_arvalid_o goes high the next cycle.
  - AR fields stay stable while arvalid & !arready. The slot clears on handshake.
  - Back-to-back acceptance gives AR bursts on consecutive cycles when arready=1.
- R beat (rvalid&rready): look up the valid entry whose id == rid.
  - No match: drop the beat, no RAM write, set biu_proto_err_o.
  - Match: in the next cycle drive wen=1, waddr={rid, beat}, wdata=rdata. err |= (rresp!=0). beat toggles.
  - rlast must equal (beat==1). On mismatch set proto_err. The entry closes only on the beat==1 beat; rlast on beat 0 does not close it.
  - Closing beat: in the next cycle, the same cycle as the final RAM write, drive biu_isu_rvalid_o=1, rid=entry id, rerr=accumulated err. The entry frees at the end of that cycle.
- Latency, from the cycle the last beat handshakes:
  - Cycle N: last-beat handshake.
  - Cycle N+1: RAM write and ISU pulse.
  - Cycle N+2: ISU may issue a RAM read.
- At most one R beat per cycle, therefore at most one ISU pulse per cycle.
- Allocation and completion may occur in the same cycle on different entries.
- Reset mid-operation: all in-flight entries are lost. Later R beats for them count as unmatched: dropped, proto_err set.

Test Plan:
- Single fill: req id=6'h05 addr=0x1000_0040, arready=1 → AR next cycle: id=5, araddr=0x1000_0040, len=1, size=4. R beats D0, D1 (rlast on beat 1) → writes waddr=0x0A, 0x0B; biu_isu_rvalid_o=1 with rid=5 on the D1 write cycle.
- Full table: 4 requests ids 1..4 accepted → ready=0. A 5th request is held until id 2 completes, then accepted in the cycle after the pulse.
- Interleaved R: beats id3-b0, id1-b0, id3-b1(last), id1-b1(last) → waddr 0x06, 0x02, 0x07, 0x03; pulses rid=3 then rid=1 on consecutive write cycles.
- Error and duplicate: rresp=2 on beat 0 of id 7 → completion pulse has rerr=1. A second request for id 7 while it is outstanding → ready=0.
- AR stall: arready=0 for 5 cycles → arvalid, arid, araddr stable; no new request accepted. Release → handshake, then the next request is accepted.
- Protocol/reset: R beat with unknown id 0x3F → no write, proto_err=1 and sticky. rst_i asserted mid-burst → all outputs 0 next cycle, proto_err cleared.

Source files
------------

// File: rtl/bank_biu_linefill.sv
// Linefill bus-interface unit: accepts ISU linefill requests, issues 2-beat AR
// bursts, writes returned R beats into the data RAM and pulses a completion
// notification back to the ISU once the second beat of a fill has landed.
module bank_biu_linefill #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 128,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  isu_biu_req_valid_i,
    output logic                  isu_biu_req_ready_o,
    input  logic [5:0]            isu_biu_req_id_i,
    input  logic [ADDR_WIDTH-1:0] isu_biu_req_addr_i,
    output logic                  biu_arvalid_o,
    input  logic                  biu_arready_i,
    output logic [5:0]            biu_arid_o,
    output logic [ADDR_WIDTH-1:0] biu_araddr_o,
    output logic [7:0]            biu_arlen_o,
    output logic [2:0]            biu_arsize_o,
    input  logic                  biu_rvalid_i,
    output logic                  biu_rready_o,
    input  logic [5:0]            biu_rid_i,
    input  logic [DATA_WIDTH-1:0] biu_rdata_i,
    input  logic [1:0]            biu_rresp_i,
    input  logic                  biu_rlast_i,
    output logic                  biu_dram_wen_o,
    output logic [6:0]            biu_dram_waddr_o,
    output logic [DATA_WIDTH-1:0] biu_dram_wdata_o,
    output logic                  biu_isu_rvalid_o,
    output logic [5:0]            biu_isu_rid_o,
    output logic                  biu_isu_rerr_o,
    output logic                  biu_proto_err_o
);
    localparam int IW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    // tracking table
    logic [OUTSTANDING-1:0]      r_vld;
    logic [OUTSTANDING-1:0]      r_beat;
    logic [OUTSTANDING-1:0]      r_err;
    logic [OUTSTANDING-1:0][5:0] r_id;
    // entry whose completion pulse is on the outputs this cycle; freed at its end
    logic                        r_cls;
    logic [IW-1:0]               r_cls_idx;
    // low for the reset cycles and the first cycle after reset
    logic                        r_live;
    // AR slot
    logic                        r_ar_vld;
    logic [5:0]                  r_ar_id;
    logic [ADDR_WIDTH-1:0]       r_ar_addr;
    // registered RAM write / ISU notification
    logic                        r_wen;
    logic [6:0]                  r_waddr;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic                        r_isu_vld;
    logic [5:0]                  r_isu_rid;
    logic                        r_isu_rerr;
    logic                        r_perr;

    logic          w_free_any, w_dup, w_ready, w_acc;
    logic [IW-1:0] w_free_idx;
    logic          w_rhs, w_hit, w_rbad, w_hit_beat;
    logic [IW-1:0] w_hit_idx;

    // lowest free entry and duplicate-id detection, from registered state only
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_dup      = 1'b0;
        for (int i = OUTSTANDING - 1; i >= 0; i--) begin
            if (!r_vld[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
        end
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (r_vld[i] && r_id[i] == isu_biu_req_id_i) w_dup = 1'b1;
        end
    end

    // R id lookup; an entry already closed is no longer a match target
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < OUTSTANDING; i++) begin
            if (r_vld[i] && !(r_cls && r_cls_idx == IW'(i)) && r_id[i] == biu_rid_i) begin
                w_hit     = 1'b1;
                w_hit_idx = IW'(i);
            end
        end
    end

    assign w_ready    = r_live & ~rst_i & w_free_any & ~w_dup & (~r_ar_vld | biu_arready_i);
    assign w_acc      = isu_biu_req_valid_i & w_ready;
    assign w_rhs      = biu_rvalid_i & r_live;
    assign w_rbad     = |biu_rresp_i;
    assign w_hit_beat = r_beat[w_hit_idx];

    // table allocation, beat tracking and deferred free
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld     <= '0;
            r_beat    <= '0;
            r_err     <= '0;
            r_id      <= '0;
            r_cls     <= 1'b0;
            r_cls_idx <= '0;
        end else begin
            if (r_cls) r_vld[r_cls_idx] <= 1'b0;
            r_cls <= 1'b0;
            if (w_acc) begin
                r_vld[w_free_idx]  <= 1'b1;
                r_id[w_free_idx]   <= isu_biu_req_id_i;
                r_beat[w_free_idx] <= 1'b0;
                r_err[w_free_idx]  <= 1'b0;
            end
            if (w_rhs && w_hit) begin
                r_beat[w_hit_idx] <= ~w_hit_beat;
                r_err[w_hit_idx]  <= r_err[w_hit_idx] | w_rbad;
                if (w_hit_beat) begin
                    r_cls     <= 1'b1;
                    r_cls_idx <= w_hit_idx;
                end
            end
        end
    end

    // AR slot: load on accept, hold while stalled, clear on handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ar_vld  <= 1'b0;
            r_ar_id   <= '0;
            r_ar_addr <= '0;
        end else if (w_acc) begin
            r_ar_vld  <= 1'b1;
            r_ar_id   <= isu_biu_req_id_i;
            r_ar_addr <= isu_biu_req_addr_i & ~ADDR_WIDTH'(5'h1f);
        end else if (r_ar_vld && biu_arready_i) begin
            r_ar_vld <= 1'b0;
        end
    end

    // RAM write, completion pulse and sticky protocol error, one cycle after the beat
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_live     <= 1'b0;
            r_wen      <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_isu_vld  <= 1'b0;
            r_isu_rid  <= '0;
            r_isu_rerr <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_live    <= 1'b1;
            r_wen     <= w_rhs & w_hit;
            r_isu_vld <= w_rhs & w_hit & w_hit_beat;
            if (w_rhs && w_hit) begin
                r_waddr <= {biu_rid_i, w_hit_beat};
                r_wdata <= biu_rdata_i;
                if (w_hit_beat) begin
                    r_isu_rid  <= biu_rid_i;
                    r_isu_rerr <= r_err[w_hit_idx] | w_rbad;
                end
                if (biu_rlast_i != w_hit_beat) r_perr <= 1'b1;
            end else if (w_rhs) begin
                r_perr <= 1'b1;
            end
        end
    end

    assign isu_biu_req_ready_o = w_ready;
    assign biu_arvalid_o       = r_ar_vld;
    assign biu_arid_o          = r_ar_id;
    assign biu_araddr_o        = r_ar_addr;
    assign biu_arlen_o         = 8'd1;
    assign biu_arsize_o        = 3'd4;
    assign biu_rready_o        = r_live;
    assign biu_dram_wen_o      = r_wen;
    assign biu_dram_waddr_o    = r_waddr;
    assign biu_dram_wdata_o    = r_wdata;
    assign biu_isu_rvalid_o    = r_isu_vld;
    assign biu_isu_rid_o       = r_isu_rid;
    assign biu_isu_rerr_o      = r_isu_rerr;
    assign biu_proto_err_o     = r_perr;
endmodule
